// File: rtl/mipi_power_sequencer_if.sv
// Avalon-MM slave bus bundle for the MIPI camera power sequencer.
//   address    : register select (0 CTRL, 1 STATUS, 2 DELAY, 3 IRQ_CLR)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, zero read latency (combinational from address)
interface mipi_power_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mipi_power_sequencer.sv
// MIPI camera power sequencer with an Avalon-MM register interface.
// Steps the camera through power-down release, master-clock enable and reset release on
// power-up, and the reverse on power-down, holding each step for DELAY+1 cycles.
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   avs        : Avalon-MM slave (CTRL / STATUS / DELAY / IRQ_CLR registers)
//   irq        : level interrupt, IRQ_PENDING and IRQ_EN
//   cam_pwdn_n : camera power-down, low = powered down
//   cam_rst_n  : camera reset, low = held in reset
//   mclk_en    : camera master-clock enable
// DELAY_WIDTH must not exceed 32 (DELAY is read back through the 32-bit data bus).
module mipi_power_sequencer #(
    parameter int unsigned DELAY_WIDTH = 16,
    parameter int unsigned DELAY_RESET = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mipi_power_sequencer_if.slave  avs,
    output logic                   irq,
    output logic                   cam_pwdn_n,
    output logic                   cam_rst_n,
    output logic                   mclk_en
);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StUpPwdn = 3'd1,
        StUpMclk = 3'd2,
        StUpRst  = 3'd3,
        StOn     = 3'd4,
        StDnRst  = 3'd5,
        StDnMclk = 3'd6
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             ctrl_q;
    logic [DELAY_WIDTH-1:0] delay_q;
    logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
    logic                   pend_q, pend_d;
    logic                   pwdn_d, mclk_d, rst_d;
    logic                   wr_en;
    logic                   cnt_done;
    logic                   busy, ready;

    assign wr_en    = avs.chipselect & ~avs.write_n;
    assign cnt_done = (cnt_q == '0);
    assign busy     = state_q inside {StUpPwdn, StUpMclk, StUpRst, StDnRst, StDnMclk};
    assign ready    = (state_q == StOn);
    assign irq      = pend_q & ctrl_q[1];

    // Next state, step counter, interrupt flag and next Moore outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        unique case (state_q)
            StOff:    if (ctrl_q[0])  state_d = StUpPwdn;
            StUpPwdn: if (cnt_done)   state_d = StUpMclk;
            StUpMclk: if (cnt_done)   state_d = StUpRst;
            StUpRst:  if (cnt_done)   state_d = StOn;
            StOn:     if (!ctrl_q[0]) state_d = StDnRst;
            StDnRst:  if (cnt_done)   state_d = StDnMclk;
            StDnMclk: if (cnt_done)   state_d = StOff;
            default:                  state_d = StOff;
        endcase

        // DELAY is sampled only on entry, so a mid-step DELAY write affects the next step.
        if (state_d != state_q &&
            state_d inside {StUpPwdn, StUpMclk, StUpRst, StDnRst, StDnMclk}) begin
            cnt_d = delay_q;
        end else if (!cnt_done) begin
            cnt_d = cnt_q - DELAY_WIDTH'(1);
        end

        // Clear first so a same-cycle completion event wins.
        if (wr_en && avs.address == 2'd3 && avs.writedata[0]) begin
            pend_d = 1'b0;
        end
        if ((state_d == StOn && state_q != StOn) ||
            (state_d == StOff && state_q == StDnMclk)) begin
            pend_d = 1'b1;
        end

        // Outputs are decoded from the next state so they register alongside it.
        pwdn_d = (state_d != StOff);
        mclk_d = state_d inside {StUpMclk, StUpRst, StOn, StDnRst};
        rst_d  = state_d inside {StUpRst, StOn};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            cam_pwdn_n <= 1'b0;
            mclk_en    <= 1'b0;
            cam_rst_n  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            cam_pwdn_n <= pwdn_d;
            mclk_en    <= mclk_d;
            cam_rst_n  <= rst_d;
        end
    end

    // Register file writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= 2'b00;
            delay_q <= DELAY_WIDTH'(DELAY_RESET);
        end else if (wr_en) begin
            if (avs.address == 2'd0) begin
                ctrl_q <= avs.writedata[1:0];
            end
            if (avs.address == 2'd2) begin
                delay_q <= avs.writedata[DELAY_WIDTH-1:0];
            end
        end
    end

    // Zero-latency read mux.
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            2'd0:    avs.readdata[1:0] = ctrl_q;
            2'd1:    avs.readdata[6:0] = {state_q, 1'b0, pend_q, busy, ready};
            2'd2:    avs.readdata[DELAY_WIDTH-1:0] = delay_q;
            default: avs.readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_mipi_power_sequencer.sv
// Scoreboard bench for mipi_power_sequencer: stimulus pushes the expected post-edge register
// and sequencer state each cycle; a monitor pops and compares at the falling edge.
module tb_mipi_power_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned DR = 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic irq, cam_pwdn_n, cam_rst_n, mclk_en;

    mipi_power_sequencer_if bus ();

    mipi_power_sequencer #(
        .DELAY_WIDTH (DW),
        .DELAY_RESET (DR)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (bus.slave),
        .irq        (irq),
        .cam_pwdn_n (cam_pwdn_n),
        .cam_rst_n  (cam_rst_n),
        .mclk_en    (mclk_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  state;
        logic        pend;
        logic [1:0]  ctrl;
        logic [15:0] delay;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: sequencer position as a step plus the cycle it was entered.
    int unsigned cyc, m_entry, m_dwell;
    logic [2:0]  m_state;
    logic        m_pend;
    logic [1:0]  m_ctrl;
    logic [15:0] m_delay;

    function automatic logic [2:0] succ(input logic [2:0] s);
        case (s)
            3'd1:    return 3'd2;
            3'd2:    return 3'd3;
            3'd3:    return 3'd4;
            3'd5:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a, input exp_t e);
        logic busy, ready;
        busy  = (e.state == 3'd1 || e.state == 3'd2 || e.state == 3'd3 ||
                 e.state == 3'd5 || e.state == 3'd6);
        ready = (e.state == 3'd4);
        case (a)
            2'd0:    return {30'd0, e.ctrl};
            2'd1:    return {25'd0, e.state, 1'b0, e.pend, busy, ready};
            2'd2:    return {16'd0, e.delay};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        cyc = 0; m_entry = 0; m_dwell = 0;
        m_state = 3'd0; m_pend = 1'b0; m_ctrl = 2'b00; m_delay = 16'(DR);
    endtask

    task automatic model_edge(input logic [1:0] a, input logic cs, input logic wn,
                              input logic [31:0] wd);
        logic [2:0] nxt;
        logic       wr;
        exp_t       e;
        wr  = cs && !wn;
        cyc = cyc + 1;
        nxt = m_state;
        if (m_state == 3'd0) begin
            if (m_ctrl[0]) nxt = 3'd1;
        end else if (m_state == 3'd4) begin
            if (!m_ctrl[0]) nxt = 3'd5;
        end else if (cyc == m_entry + m_dwell) begin
            nxt = succ(m_state);
        end
        if (wr && a == 2'd3 && wd[0]) m_pend = 1'b0;
        if (nxt != m_state) begin
            m_entry = cyc;
            m_dwell = 32'(m_delay) + 1;
            if (nxt == 3'd4 || nxt == 3'd0) m_pend = 1'b1;
        end
        if (wr && a == 2'd0) m_ctrl = wd[1:0];
        if (wr && a == 2'd2) m_delay = wd[15:0];
        m_state = nxt;
        e.state = m_state; e.pend = m_pend; e.ctrl = m_ctrl; e.delay = m_delay;
        exp_q.push_back(e);
    endtask

    // Monitor: invariant every cycle, scoreboard entry whenever one is waiting.
    initial begin
        exp_t        e;
        logic [35:0] got, want;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                vectors++;
                if (cam_rst_n && (!mclk_en || !cam_pwdn_n)) begin
                    miscompares++;
                    $display("FAIL invariant t=%0t rst_n=%b mclk_en=%b pwdn_n=%b",
                             $time, cam_rst_n, mclk_en, cam_pwdn_n);
                end
            end
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                got  = {cam_pwdn_n, mclk_en, cam_rst_n, irq, bus.readdata};
                want = {e.state != 3'd0,
                        (e.state == 3'd2 || e.state == 3'd3 || e.state == 3'd4 ||
                         e.state == 3'd5),
                        (e.state == 3'd3 || e.state == 3'd4),
                        e.pend & e.ctrl[1],
                        exp_rd(bus.address, e)};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t addr=%0d got pwdn/mclk/rst/irq=%b rd=%h want %b rd=%h (state %0d)",
                             $time, bus.address, got[35:32], got[31:0], want[35:32],
                             want[31:0], e.state);
                end
            end
        end
    end

    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd);
        bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
        @(posedge clk);
        #1;
        model_edge(a, cs, wn, wd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d);
    endtask

    // Idle cycles with random non-write bus activity and random read addresses.
    task automatic idle(input int n);
        logic cs;
        for (int i = 0; i < n; i++) begin
            cs = 1'($urandom);
            step(2'($urandom_range(0, 3)), cs, cs ? 1'b1 : 1'($urandom), $urandom);
        end
    endtask

    task automatic reset_check();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd1;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({cam_pwdn_n, mclk_en, cam_rst_n, irq} !== 4'b0000 || bus.readdata !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset got pwdn/mclk/rst/irq=%b status=%h want 0000 status=0",
                     {cam_pwdn_n, mclk_en, cam_rst_n, irq}, bus.readdata);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int sel;
        bus.address = 2'd1; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        model_reset();
        reset_check();
        idle(2);

        // Power-up and power-down with DELAY=3.
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h1);
        idle(14);
        wr(2'd0, 32'h0);
        idle(10);

        // Interrupt enable, completion, clear.
        wr(2'd0, 32'h2);
        wr(2'd0, 32'h3);
        idle(14);
        wr(2'd3, 32'h1);
        idle(2);
        wr(2'd0, 32'h2);
        idle(10);
        wr(2'd3, 32'h1);

        // DELAY=0, IRQ_CLR coincident with ON entry.
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h3);
        idle(3);
        wr(2'd3, 32'h1);
        idle(2);
        wr(2'd0, 32'h2);
        idle(6);

        // Request dropped during UP_MCLK: sequence completes then powers down.
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h3);
        idle(5);
        wr(2'd0, 32'h2);
        idle(20);

        // Reset during UP_RST.
        wr(2'd0, 32'h1);
        idle(10);
        reset_check();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40) idle($urandom_range(1, 12));
            else if (sel < 65) wr(2'd0, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)));
            else if (sel < 80) wr(2'd2, ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5)));
            else if (sel < 92) wr(2'd3, $urandom);
            else if (sel < 98) wr(2'd1, $urandom);
            else reset_check();
        end

        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mipi_power_sequencer.md
MIPI_POWER_SEQUENCER -- requirements
Module: mipi_power_sequencer

Interface
REQ-001 SHALL have parameter DELAY_WIDTH, default 16, width of the step-delay counter and DELAY register.
REQ-002 SHALL have parameter DELAY_RESET, default 1000, reset value of the DELAY register.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port address, input, 2, Avalon-MM register select.
REQ-006 SHALL have port chipselect, input, 1, Avalon-MM slave select.
REQ-007 SHALL have port write_n, input, 1, Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-009 SHALL have port readdata, output, 32, Avalon-MM read data, zero read latency.
REQ-010 SHALL have port irq, output, 1, level interrupt, active-high.
REQ-011 SHALL have port cam_pwdn_n, output, 1, camera power-down, low = powered down.
REQ-012 SHALL have port cam_rst_n, output, 1, camera reset, low = held in reset.
REQ-013 SHALL have port mclk_en, output, 1, camera master-clock enable.

Function
REQ-014 SHALL decode registers: 0 CTRL rw (bit0 POWER_REQ, bit1 IRQ_EN); 1 STATUS ro (bit0 READY, bit1 BUSY, bit2 IRQ_PENDING, bits6:4 state code); 2 DELAY rw (bits DELAY_WIDTH-1:0); 3 IRQ_CLR wo (writing bit0=1 clears IRQ_PENDING).
REQ-015 SHALL accept a write when chipselect=1 and write_n=0; unused writedata bits ignored.
REQ-016 SHALL drive readdata combinationally from address; unused bits and address 3 read 0.
REQ-017 SHALL implement FSM, codes: OFF=0, UP_PWDN=1, UP_MCLK=2, UP_RST=3, ON=4, DN_RST=5, DN_MCLK=6.
REQ-018 SHALL transition OFF->UP_PWDN when POWER_REQ=1, and ON->DN_RST when POWER_REQ=0, evaluated on the edge after the CTRL write is registered.
REQ-019 SHALL load the step counter with DELAY on entry to each wait state (1,2,3,5,6), decrement per cycle, and advance when counter=0; dwell = DELAY+1 cycles; DELAY=0 gives 1 cycle.
REQ-020 SHALL advance UP_PWDN->UP_MCLK->UP_RST->ON and DN_RST->DN_MCLK->OFF.
REQ-021 SHALL complete an in-progress sequence regardless of POWER_REQ changes; POWER_REQ is re-evaluated only in OFF or ON.
REQ-022 SHALL apply a DELAY write during a wait state only at the next state entry.
REQ-023 SHALL drive registered Moore outputs: cam_pwdn_n=1 in all states except OFF; mclk_en=1 in UP_MCLK, UP_RST, ON, DN_RST; cam_rst_n=1 in UP_RST and ON only.
REQ-024 SHALL set READY=1 only in ON, and BUSY=1 in states 1,2,3,5,6.
REQ-025 SHALL set IRQ_PENDING on entry to ON or to OFF from DN_MCLK; set wins over a same-cycle IRQ_CLR.
REQ-026 SHALL drive irq = IRQ_PENDING AND IRQ_EN.
REQ-027 SHALL never have cam_rst_n=1 while mclk_en=0 or cam_pwdn_n=0.

Reset
REQ-028 SHALL, on reset_n=0, immediately force state OFF, CTRL=0, DELAY=DELAY_RESET, counter=0, IRQ_PENDING=0, cam_pwdn_n=0, cam_rst_n=0, mclk_en=0, irq=0.
REQ-029 SHALL, on reset assertion mid-sequence, abandon the sequence with outputs taking reset values asynchronously.

Verification
REQ-030 SHALL verify power-up: DELAY=3, write CTRL=0x1 at edge E -> UP_PWDN at E+1, UP_MCLK at E+5, UP_RST at E+9, ON at E+13; READY=1, IRQ_PENDING=1.
REQ-031 SHALL verify power-down from ON with DELAY=3: write CTRL=0x0 -> cam_rst_n=0 next state, mclk_en=0 4 cycles later, cam_pwdn_n=0 and OFF 4 cycles after that.
REQ-032 SHALL verify interrupt: IRQ_EN=1, complete power-up -> irq=1; write IRQ_CLR=1 -> irq=0 next cycle; IRQ_CLR coincident with ON entry -> IRQ_PENDING stays 1.
REQ-033 SHALL verify mid-sequence request change: write CTRL=0x0 during UP_MCLK -> sequence reaches ON, then proceeds DN_RST without further write.
REQ-034 SHALL verify DELAY=0 -> each wait state lasts exactly 1 cycle, ON reached 4 cycles after request registered.
REQ-035 SHALL verify reset_n asserted in UP_RST -> all outputs 0 and STATUS=0 without waiting for a clock edge; REQ-027 invariant checked throughout.
